// File: rtl/arm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arm_pkg: shared codes for the ARM execute stage.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package arm_pkg;

   typedef enum logic [3:0] {
      CMD_NOP = 4'b0000,
      CMD_MOV = 4'b0001,
      CMD_ADD = 4'b0010,
      CMD_ADC = 4'b0011,
      CMD_SUB = 4'b0100,
      CMD_SBC = 4'b0101,
      CMD_AND = 4'b0110,
      CMD_ORR = 4'b0111,
      CMD_EOR = 4'b1000,
      CMD_MVN = 4'b1001
   } exe_cmd_e;

   localparam logic [1:0] c_shift_lsl = 2'b00;
   localparam logic [1:0] c_shift_lsr = 2'b01;
   localparam logic [1:0] c_shift_asr = 2'b10;
   localparam logic [1:0] c_shift_ror = 2'b11;

   localparam logic [1:0] c_sel_rf  = 2'b00;
   localparam logic [1:0] c_sel_mem = 2'b01;
   localparam logic [1:0] c_sel_wb  = 2'b10;

   localparam int c_flag_n = 3;
   localparam int c_flag_z = 2;
   localparam int c_flag_c = 1;
   localparam int c_flag_v = 0;

   // Select code 11 is unused by the hazard unit and falls back to the register file.
   function automatic logic [31:0] fwd_sel(input logic [1:0] sel, input logic [31:0] rf,
                                           input logic [31:0] mem, input logic [31:0] wb);
      logic [31:0] v;
      v = rf;
      if (sel == c_sel_mem)
         v = mem;
      else if (sel == c_sel_wb)
         v = wb;
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/exe_stage_val2_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | val2_gen: second-operand generator (rotated immediate, shifter,      |
// | load/store offset).                                                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module val2_gen
   import arm_pkg::*;
(
   input  logic [31:0] rm,
   input  logic [11:0] shift_operand,
   input  logic        imm,
   input  logic        mem_access,
   output logic [31:0] val2
);

   logic [4:0]  w_rot_amt;
   logic [4:0]  w_sh_amt;
   logic [63:0] w_imm_dbl;
   logic [63:0] w_rm_dbl;
   logic [31:0] w_shifted;
   logic        w_unused;

   assign w_rot_amt = {shift_operand[11:8], 1'b0};
   assign w_sh_amt  = shift_operand[11:7];
   // Rotation is taken from the low half of a doubled word shifted right.
   assign w_imm_dbl = {24'b0, shift_operand[7:0], 24'b0, shift_operand[7:0]} >> w_rot_amt;
   assign w_rm_dbl  = {rm, rm} >> w_sh_amt;
   assign w_unused  = shift_operand[4];

   always_comb begin
      w_shifted = rm;
      case (shift_operand[6:5])
         c_shift_lsl: w_shifted = rm << w_sh_amt;
         c_shift_lsr: w_shifted = rm >> w_sh_amt;
         c_shift_asr: w_shifted = $unsigned($signed(rm) >>> w_sh_amt);
         c_shift_ror: w_shifted = w_rm_dbl[31:0];
         default:     w_shifted = rm;
      endcase
   end

   always_comb begin
      if (mem_access)
         val2 = {20'b0, shift_operand};
      else if (imm)
         val2 = w_imm_dbl[31:0];
      else
         val2 = w_shifted;
   end

endmodule
`default_nettype wire

// File: rtl/exe_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exe_stage: ARM pipeline execute stage - forwarding, ALU, branch      |
// | target and the NZCV status register.                                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module exe_stage
   import arm_pkg::*;
#(
   parameter int WIDTH = 32
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       exe_cmd,
   input  logic             s_in,
   input  logic             imm,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic             b_in,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] val_rn,
   input  logic [WIDTH-1:0] val_rm,
   input  logic [11:0]      shift_operand,
   input  logic [23:0]      signed_imm_24,
   input  logic [1:0]       sel_src1,
   input  logic [1:0]       sel_src2,
   input  logic [WIDTH-1:0] fwd_mem,
   input  logic [WIDTH-1:0] fwd_wb,
   output logic [WIDTH-1:0] alu_result,
   output logic [WIDTH-1:0] store_val,
   output logic             branch_taken,
   output logic [WIDTH-1:0] branch_addr,
   output logic [3:0]       sr
);

   logic [WIDTH-1:0] w_op1;
   logic [WIDTH-1:0] w_rm;
   logic [WIDTH-1:0] w_val2;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_result;
   logic [3:0]       w_flags;
   logic             w_cin;
   logic             w_arith;
   logic             w_valid_op;
   logic [3:0]       r_sr;

   assign w_op1 = fwd_sel(sel_src1, val_rn, fwd_mem, fwd_wb);
   assign w_rm  = fwd_sel(sel_src2, val_rm, fwd_mem, fwd_wb);

   val2_gen u_val2_gen (
      .rm            (w_rm),
      .shift_operand (shift_operand),
      .imm           (imm),
      .mem_access    (mem_read | mem_write),
      .val2          (w_val2)
   );

   // Subtraction is op1 + ~val2 + carry-in, so C comes out as "no borrow".
   always_comb begin
      w_b        = w_val2;
      w_cin      = 1'b0;
      w_arith    = 1'b0;
      w_valid_op = 1'b1;
      w_result   = '0;
      case (exe_cmd)
         CMD_MOV: w_result = w_val2;
         CMD_MVN: w_result = ~w_val2;
         CMD_ADD: w_arith = 1'b1;
         CMD_ADC: begin w_arith = 1'b1; w_cin = r_sr[c_flag_c]; end
         CMD_SUB: begin w_arith = 1'b1; w_b = ~w_val2; w_cin = 1'b1; end
         CMD_SBC: begin w_arith = 1'b1; w_b = ~w_val2; w_cin = r_sr[c_flag_c]; end
         CMD_AND: w_result = w_op1 & w_val2;
         CMD_ORR: w_result = w_op1 | w_val2;
         CMD_EOR: w_result = w_op1 ^ w_val2;
         default: w_valid_op = 1'b0;
      endcase
      w_sum = {1'b0, w_op1} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};
      if (w_arith)
         w_result = w_sum[WIDTH-1:0];

      w_flags           = r_sr;
      w_flags[c_flag_n] = w_result[WIDTH-1];
      w_flags[c_flag_z] = (w_result == '0);
      if (w_arith) begin
         w_flags[c_flag_c] = w_sum[WIDTH];
         w_flags[c_flag_v] = (w_op1[WIDTH-1] == w_b[WIDTH-1]) &&
                             (w_result[WIDTH-1] != w_op1[WIDTH-1]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_sr <= 4'b0000;
      else if (s_in && w_valid_op)
         r_sr <= w_flags;
   end

   assign alu_result   = w_result;
   assign store_val    = w_rm;
   assign branch_taken = b_in;
   assign branch_addr  = pc + {{(WIDTH-26){signed_imm_24[23]}}, signed_imm_24, 2'b00};
   assign sr           = r_sr;

endmodule
`default_nettype wire

// File: tb/tb_exe_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_exe_stage: directed vectors checked against a behavioural model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_exe_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  exe_cmd;
   logic        s_in, imm, mem_read, mem_write, b_in;
   logic [31:0] pc, val_rn, val_rm, fwd_mem, fwd_wb;
   logic [11:0] shift_operand;
   logic [23:0] signed_imm_24;
   logic [1:0]  sel_src1, sel_src2;
   logic [31:0] alu_result, store_val, branch_addr;
   logic        branch_taken;
   logic [3:0]  sr;

   int n_vec = 0;
   int n_err = 0;

   logic [3:0] m_sr = 4'b0000;
   logic       m_valid = 1'b0;

   always #5 clk = ~clk;

   exe_stage #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .exe_cmd(exe_cmd), .s_in(s_in), .imm(imm),
      .mem_read(mem_read), .mem_write(mem_write), .b_in(b_in), .pc(pc),
      .val_rn(val_rn), .val_rm(val_rm), .shift_operand(shift_operand),
      .signed_imm_24(signed_imm_24), .sel_src1(sel_src1), .sel_src2(sel_src2),
      .fwd_mem(fwd_mem), .fwd_wb(fwd_wb), .alu_result(alu_result),
      .store_val(store_val), .branch_taken(branch_taken),
      .branch_addr(branch_addr), .sr(sr)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [31:0] m_fwd(input logic [1:0] sel, input logic [31:0] rf);
      if (sel == 2'b01) return fwd_mem;
      if (sel == 2'b10) return fwd_wb;
      return rf;
   endfunction

   function automatic logic [31:0] m_val2(input logic [31:0] rm);
      logic [31:0] v;
      int n;
      if (mem_read || mem_write) return {20'b0, shift_operand};
      if (imm) begin
         v = {24'b0, shift_operand[7:0]};
         n = 2 * shift_operand[11:8];
         for (int i = 0; i < n; i++) v = {v[0], v[31:1]};
         return v;
      end
      v = rm;
      n = shift_operand[11:7];
      for (int i = 0; i < n; i++) begin
         case (shift_operand[6:5])
            2'd0: v = {v[30:0], 1'b0};
            2'd1: v = {1'b0, v[31:1]};
            2'd2: v = {v[31], v[31:1]};
            default: v = {v[0], v[31:1]};
         endcase
      end
      return v;
   endfunction

   function automatic void m_add(input logic [31:0] a, input logic [31:0] b, input logic ci,
                                 output logic [31:0] res, output logic c, output logic v);
      longint unsigned u;
      longint s;
      u   = {32'b0, a} + {32'b0, b} + {63'b0, ci};
      s   = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
      res = u[31:0];
      c   = u[32];
      v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
   endfunction

   function automatic void m_exec(input logic [3:0] sr_in, output logic [31:0] res,
                                  output logic [3:0] f);
      logic [31:0] op1, v2;
      logic c, v;
      op1 = m_fwd(sel_src1, val_rn);
      v2  = m_val2(m_fwd(sel_src2, val_rm));
      c   = sr_in[1];
      v   = sr_in[0];
      res = 32'h0;
      case (exe_cmd)
         4'd1: res = v2;
         4'd9: res = ~v2;
         4'd2: m_add(op1, v2, 1'b0, res, c, v);
         4'd3: m_add(op1, v2, sr_in[1], res, c, v);
         4'd4: m_add(op1, ~v2, 1'b1, res, c, v);
         4'd5: m_add(op1, ~v2, sr_in[1], res, c, v);
         4'd6: res = op1 & v2;
         4'd7: res = op1 | v2;
         4'd8: res = op1 ^ v2;
         default: begin f = sr_in; return; end
      endcase
      f = {res[31], res == 32'h0, c, v};
   endfunction

   always @(posedge clk) begin : model_sr
      logic [31:0] r;
      logic [3:0]  f;
      if (!rst_n) begin
         m_sr    <= 4'b0000;
         m_valid <= 1'b1;
      end else if (s_in) begin
         m_exec(m_sr, r, f);
         m_sr <= f;
      end
   end

   always @(negedge clk) begin : compare
      logic [31:0] e_res;
      logic [3:0]  e_f;
      int          off;
      if (m_valid) begin
         m_exec(m_sr, e_res, e_f);
         off = $signed(signed_imm_24);
         chk("alu_result", alu_result, e_res);
         chk("store_val", store_val, m_fwd(sel_src2, val_rm));
         chk("branch_addr", branch_addr, pc + 32'(off * 4));
         chk("branch_taken", {31'b0, branch_taken}, {31'b0, b_in});
         chk("sr", {28'b0, sr}, {28'b0, m_sr});
      end
   end

   // ---------------- stimulus ----------------
   task automatic clr();
      exe_cmd = 4'd0; s_in = 0; imm = 0; mem_read = 0; mem_write = 0; b_in = 0;
      pc = 0; val_rn = 0; val_rm = 0; fwd_mem = 0; fwd_wb = 0;
      shift_operand = 0; signed_imm_24 = 0; sel_src1 = 0; sel_src2 = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] exp_sh [4] = '{32'h00000002, 32'h40000000, 32'hC0000000, 32'hC0000000};
   logic [3:0]  ops [8]    = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
   logic [31:0] opa [3]    = '{32'h7FFFFFFF, 32'h00000000, 32'hA5A5F00F};

   initial begin
      clk = 1'b0;
      clk = 1'b0;
      clr();
      rst_n = 0; s_in = 1; exe_cmd = 4'd4; val_rn = 5; val_rm = 5;
      @(negedge clk); chk("rst_sub_res", alu_result, 32'h0);
      tick();         chk("rst_sr", {28'b0, sr}, 32'h0);

      rst_n = 1;      // CMP 5,5
      @(negedge clk); chk("cmp_res", alu_result, 32'h0);
      tick();         chk("cmp_sr", {28'b0, sr}, 32'h6);

      clr(); exe_cmd = 4'd1; imm = 1; shift_operand = 12'h4FF; s_in = 1;
      @(negedge clk); chk("imm_rot", alu_result, 32'hFF000000);
      tick();         chk("imm_rot_sr", {28'b0, sr}, 32'hA);

      for (int t = 0; t < 4; t++) begin
         clr(); exe_cmd = 4'd1; val_rm = 32'h80000001;
         shift_operand = {5'd1, t[1:0], 5'd0};
         @(negedge clk); chk("shift", alu_result, exp_sh[t]);
         tick();
      end

      clr(); exe_cmd = 4'd2; val_rn = 32'hFFFFFFFF; imm = 1; shift_operand = 12'h001; s_in = 1;
      @(negedge clk); chk("add_wrap", alu_result, 32'h0);
      tick();         chk("add_wrap_sr", {28'b0, sr}, 32'h6);
      clr(); exe_cmd = 4'd3; imm = 1;
      @(negedge clk); chk("adc_carry", alu_result, 32'h1);
      tick();

      clr(); exe_cmd = 4'd4; val_rn = 32'h80000000; imm = 1; shift_operand = 12'h001; s_in = 1;
      @(negedge clk); chk("sub_ovf", alu_result, 32'h7FFFFFFF);
      tick();         chk("sub_ovf_sr", {28'b0, sr}, 32'h3);

      clr(); exe_cmd = 4'd2; sel_src1 = 2'b01; fwd_mem = 10; val_rn = 999; imm = 1;
      shift_operand = 12'h003;
      @(negedge clk); chk("fwd_mem", alu_result, 32'd13);
      sel_src1 = 2'b11;
      @(negedge clk); chk("sel_11", alu_result, 32'd1002);
      tick();
      clr(); exe_cmd = 4'd2; mem_write = 1; sel_src2 = 2'b10; fwd_wb = 7; val_rm = 55;
      val_rn = 32'h1000; shift_operand = 12'h008;
      @(negedge clk); chk("str_val", store_val, 32'd7); chk("str_addr", alu_result, 32'h1008);
      tick();

      clr(); b_in = 1; pc = 32'h100; signed_imm_24 = 24'hFFFFFE;
      @(negedge clk); chk("br_addr", branch_addr, 32'hF8);
      chk("br_taken", {31'b0, branch_taken}, 32'h1);
      tick();

      clr();          // bubble
      @(negedge clk); chk("bubble_res", alu_result, 32'h0);
      tick();         chk("bubble_sr", {28'b0, sr}, 32'h3);
      clr(); exe_cmd = 4'b1010; val_rn = 32'h12345678; s_in = 1;
      @(negedge clk); chk("undef_res", alu_result, 32'h0);
      tick();         chk("undef_sr", {28'b0, sr}, 32'h3);

      // Mixed ops with flag updates; the model tracks every cycle.
      for (int o = 0; o < 8; o++) begin
         for (int a = 0; a < 3; a++) begin
            clr(); exe_cmd = ops[o]; s_in = 1; val_rn = opa[a]; val_rm = opa[(a + 1) % 3];
            shift_operand = {5'(a * 3), 2'(o), 5'd0};
            tick();
         end
      end

      clr(); rst_n = 0; exe_cmd = 4'd2; val_rn = 32'h80000000; s_in = 1;
      tick();         chk("midrst_sr", {28'b0, sr}, 32'h0);
      rst_n = 1; clr();
      tick();
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
